// File: rtl/prog_freq_divider_pkg.sv
// Shared constants for the programmable frequency divider.
//   DEF_WIDTH : default counter width in bits
//   DIR_UP    : up_dn_i value selecting up counting
//   DIR_DN    : up_dn_i value selecting down counting
package prog_freq_divider_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam logic        DIR_UP    = 1'b1;
    localparam logic        DIR_DN    = 1'b0;

endpackage

// File: rtl/prog_freq_divider_cnt_next.sv
// cnt_next: combinational next-count and wrap detection for prog_freq_divider.
// Ports:
//   q_i     : current count
//   max_i   : modulus in effect for this edge (count range 0..max)
//   up_dn_i : direction, DIR_UP / DIR_DN
//   en_i    : count enable; when low the count holds and no wrap is flagged
//   q_nxt_o : count after this edge, assuming no clear/load
//   wrap_o  : this edge wraps (up past max, or down past 0)
module prog_freq_divider_cnt_next
    import prog_freq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] max_i,
    input  logic             up_dn_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] q_nxt_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    always_comb begin
        q_nxt_o = q_i;
        wrap_o  = 1'b0;
        if (en_i) begin
            if (up_dn_i == DIR_UP) begin
                // >= rather than == so a count stranded above a lowered max wraps at once
                if (q_i >= max_i) begin
                    q_nxt_o = '0;
                    wrap_o  = 1'b1;
                end else begin
                    q_nxt_o = q_i + One;
                end
            end else begin
                if (q_i == '0) begin
                    q_nxt_o = max_i;
                    wrap_o  = 1'b1;
                end else begin
                    q_nxt_o = q_i - One;
                end
            end
        end
    end

endmodule

// File: rtl/prog_freq_divider.sv
// Programmable up/down modulus counter with terminal-count pulse and divided clock.
// Ports:
//   clk_i       : clock, all state on rising edge
//   rst_ni      : asynchronous active-low reset (deassertion synchronised externally)
//   clr_i       : synchronous clear of the count (highest priority)
//   load_i      : synchronous load of load_val_i, clamped to the current modulus
//   load_val_i  : value to load
//   en_i        : count enable
//   up_dn_i     : direction (1 = up, 0 = down)
//   max_wr_i    : write strobe for the modulus register
//   max_val_i   : new modulus (terminal value)
//   q_o         : registered count
//   tc_o        : registered one-cycle pulse, high while q_o shows a wrapped value
//   div_out_o   : registered divided clock, toggles on every wrap
module prog_freq_divider
    import prog_freq_divider_pkg::*;
#(
    parameter int unsigned      WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_MAX = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             up_dn_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             max_wr_i,
    input  logic [WIDTH-1:0] max_val_i,
    output logic [WIDTH-1:0] q_o,
    output logic             tc_o,
    output logic             div_out_o
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic             tc_q, tc_d;
    logic             div_q, div_d;

    logic [WIDTH-1:0] q_nxt;
    logic             wrap;
    logic [WIDTH-1:0] load_clamped;

    prog_freq_divider_cnt_next #(
        .WIDTH (WIDTH)
    ) u_cnt_next (
        .q_i     (q_q),
        .max_i   (max_q),
        .up_dn_i (up_dn_i),
        .en_i    (en_i),
        .q_nxt_o (q_nxt),
        .wrap_o  (wrap)
    );

    // Clamp uses the modulus in effect before this edge, even if max_wr_i is also high.
    assign load_clamped = (load_val_i > max_q) ? max_q : load_val_i;

    always_comb begin
        q_d   = q_q;
        tc_d  = 1'b0;
        div_d = div_q;
        max_d = max_wr_i ? max_val_i : max_q;
        if (clr_i) begin
            q_d = '0;
        end else if (load_i) begin
            q_d = load_clamped;
        end else begin
            // cnt_next already holds the count and suppresses wrap when en_i is low
            q_d   = q_nxt;
            tc_d  = wrap;
            div_d = div_q ^ wrap;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q   <= '0;
            max_q <= RST_MAX;
            tc_q  <= 1'b0;
            div_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            max_q <= max_d;
            tc_q  <= tc_d;
            div_q <= div_d;
        end
    end

    assign q_o       = q_q;
    assign tc_o      = tc_q;
    assign div_out_o = div_q;

endmodule

// File: tb/tb_prog_freq_divider.sv
// Directed testbench for prog_freq_divider (WIDTH = 8, RST_MAX = 255).
module tb_prog_freq_divider;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [7:0] load_val;
    logic       max_wr;
    logic [7:0] max_val;
    logic [7:0] q;
    logic       tc;
    logic       div_out;

    int checks = 0;
    int errors = 0;
    int tc_cnt;
    int div_hi;

    prog_freq_divider #(
        .WIDTH   (8),
        .RST_MAX (8'd255)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clr_i      (clr),
        .en_i       (en),
        .up_dn_i    (up_dn),
        .load_i     (load),
        .load_val_i (load_val),
        .max_wr_i   (max_wr),
        .max_val_i  (max_val),
        .q_o        (q),
        .tc_o       (tc),
        .div_out_o  (div_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; en = 1'b0; up_dn = 1'b1;
        load = 1'b0; load_val = '0; max_wr = 1'b0; max_val = '0;

        // Reset state
        #2;
        check("rst_q", q, 0);
        check("rst_tc", tc, 0);
        check("rst_div", div_out, 0);
        tick(); tick();
        @(negedge clk);
        rst_n = 1'b1;

        // Full-range up count, max = 255
        en = 1'b1; up_dn = 1'b1;
        tick();
        check("up_first", q, 1);
        repeat (254) tick();
        check("up_255_q", q, 255);
        check("up_255_tc", tc, 0);
        check("up_255_div", div_out, 0);
        tick();
        check("wrap255_q", q, 0);
        check("wrap255_tc", tc, 1);
        check("wrap255_div", div_out, 1);
        tick();
        check("post_wrap_q", q, 1);
        check("post_wrap_tc", tc, 0);
        repeat (255) tick();
        check("wrap2_q", q, 0);
        check("wrap2_tc", tc, 1);
        check("div_period512", div_out, 0);

        // Modulus 9; en=0 holds and drops tc
        en = 1'b0; max_wr = 1'b1; max_val = 8'd9;
        tick();
        max_wr = 1'b0;
        check("hold_q", q, 0);
        check("hold_tc", tc, 0);
        check("hold_div", div_out, 0);
        en = 1'b1;
        tc_cnt = 0; div_hi = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tc) tc_cnt++;
            if (div_out) div_hi++;
        end
        check("mod10_tc_count", tc_cnt, 2);
        check("mod10_div_high", div_hi, 10);
        check("mod10_end_q", q, 0);
        check("mod10_end_div", div_out, 0);

        // Down count from 0 with max = 9
        up_dn = 1'b0;
        tick();
        check("dn_wrap_q", q, 9);
        check("dn_wrap_tc", tc, 1);
        check("dn_wrap_div", div_out, 1);
        tick();
        check("dn_8_q", q, 8);
        check("dn_8_tc", tc, 0);
        tick();
        check("dn_7_q", q, 7);

        // Load clamps to max; clr beats load and leaves div_out alone
        load = 1'b1; load_val = 8'd200;
        tick();
        check("load_clamp_q", q, 9);
        check("load_tc", tc, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_load_q", q, 0);
        check("clr_div", div_out, 1);

        // Load with simultaneous max_wr clamps to the old modulus
        en = 1'b0; up_dn = 1'b1;
        load_val = 8'd50; max_wr = 1'b1; max_val = 8'd255;
        tick();
        max_wr = 1'b0;
        check("load_old_max_q", q, 9);
        tick();
        load = 1'b0;
        check("load_50_q", q, 50);

        // Lower max below the count; up count wraps on the next enabled edge
        max_wr = 1'b1; max_val = 8'd20;
        tick();
        max_wr = 1'b0;
        check("shrink_hold_q", q, 50);
        en = 1'b1;
        tick();
        check("shrink_wrap_q", q, 0);
        check("shrink_wrap_tc", tc, 1);
        check("shrink_wrap_div", div_out, 0);
        en = 1'b0;
        tick();
        check("en0_q", q, 0);
        check("en0_tc", tc, 0);
        check("en0_div", div_out, 0);

        // max = 0: every enabled edge wraps, either direction
        max_wr = 1'b1; max_val = 8'd0;
        tick();
        max_wr = 1'b0;
        en = 1'b1;
        tick();
        check("max0_a_q", q, 0);
        check("max0_a_tc", tc, 1);
        check("max0_a_div", div_out, 1);
        tick();
        check("max0_b_tc", tc, 1);
        check("max0_b_div", div_out, 0);
        up_dn = 1'b0;
        tick();
        check("max0_dn_q", q, 0);
        check("max0_dn_tc", tc, 1);
        check("max0_dn_div", div_out, 1);

        // Async reset between edges at q = 123
        en = 1'b0; up_dn = 1'b1; max_wr = 1'b1; max_val = 8'd255;
        tick();
        max_wr = 1'b0;
        load = 1'b1; load_val = 8'd123;
        tick();
        load = 1'b0;
        check("pre_rst_q", q, 123);
        en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_q", q, 0);
        check("async_rst_tc", tc, 0);
        check("async_rst_div", div_out, 0);
        #1;
        rst_n = 1'b1;
        tick();
        check("resume_1", q, 1);
        tick();
        check("resume_2", q, 2);
        tick();
        check("resume_3", q, 3);
        // Modulus back to 255: a large load is not clamped
        load = 1'b1; load_val = 8'd200;
        tick();
        load = 1'b0;
        check("rst_max255_load", q, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
